// File: rtl/term_src_arbiter_if.sv
// Handshake bundle between the local source FIFOs, the arbiter and one router terminal input.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface term_src_arbiter_if #(
    parameter int N_REQ   = 4,
    parameter int pckg_sz = 40
);
    logic [N_REQ-1:0]         req_pndng;
    logic [N_REQ*pckg_sz-1:0] req_data;
    logic [N_REQ-1:0]         req_pop;
    logic [N_REQ-1:0]         req_en;
    logic                     pndng_o;
    logic [pckg_sz-1:0]       data_o;
    logic                     popin;

    modport master (
        input  req_pndng,
        input  req_data,
        input  req_en,
        input  popin,
        output req_pop,
        output pndng_o,
        output data_o
    );

    modport slave (
        output req_pndng,
        output req_data,
        output req_en,
        output popin,
        input  req_pop,
        input  pndng_o,
        input  data_o
    );
endinterface

// File: rtl/term_src_arbiter.sv
// Round-robin arbiter feeding one mesh terminal from N_REQ packet FIFOs, with
// saturating per-source grant counters and a sticky stall watchdog.
module term_src_arbiter #(
    parameter int N_REQ     = 4,
    parameter int pckg_sz   = 40,
    parameter int CNT_W     = 16,
    parameter int STALL_LIM = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    term_src_arbiter_if.master     bus,
    output logic [N_REQ*CNT_W-1:0] gnt_cnt,
    output logic                   stall,
    input  logic                   clr
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SC_W  = $clog2(STALL_LIM + 1);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    out_state_t         state_r;
    logic               pndng_r;
    logic [pckg_sz-1:0] data_r;
    logic [PTR_W-1:0]   rr_ptr_r;
    logic [CNT_W-1:0]   cnt_r [N_REQ];
    logic [SC_W-1:0]    stall_cnt_r;
    logic               stall_r;

    logic               slot_free_s;
    logic [N_REQ-1:0]   cand_s;
    logic               found_s;
    logic [PTR_W-1:0]   win_s;
    logic               grant_s;
    logic [N_REQ-1:0]   pop_s;
    logic [pckg_sz-1:0] win_data_s;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] w);
        if (w == PTR_W'(N_REQ - 1)) begin
            return '0;
        end else begin
            return w + PTR_W'(1);
        end
    endfunction

    // Winner search: first candidate at or above rr_ptr, wrapping; masked while in reset.
    always_comb begin
        int idx;
        idx         = 0;
        slot_free_s = !pndng_r | bus.popin;
        cand_s      = bus.req_pndng & bus.req_en;
        found_s     = 1'b0;
        win_s       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_r) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end else begin
                idx = idx;
            end
            if (!found_s && cand_s[idx]) begin
                found_s = 1'b1;
                win_s   = PTR_W'(idx);
            end else begin
                found_s = found_s;
            end
        end
        grant_s = slot_free_s & found_s & reset;
        pop_s   = '0;
        if (grant_s) begin
            pop_s[win_s] = 1'b1;
        end else begin
            pop_s = '0;
        end
        win_data_s = bus.req_data[int'(win_s)*pckg_sz +: pckg_sz];
    end

    // Output register FSM: EMPTY/FULL holding slot, data capture and pointer advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= EMPTY;
            pndng_r  <= 1'b0;
            data_r   <= '0;
            rr_ptr_r <= '0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (grant_s) begin
                        state_r  <= FULL;
                        pndng_r  <= 1'b1;
                        data_r   <= win_data_s;
                        rr_ptr_r <= next_ptr(win_s);
                    end else begin
                        state_r  <= EMPTY;
                        pndng_r  <= 1'b0;
                    end
                end
                FULL: begin
                    if (grant_s) begin
                        state_r  <= FULL;
                        pndng_r  <= 1'b1;
                        data_r   <= win_data_s;
                        rr_ptr_r <= next_ptr(win_s);
                    end else if (bus.popin) begin
                        state_r  <= EMPTY;
                        pndng_r  <= 1'b0;
                    end else begin
                        state_r  <= FULL;
                        pndng_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= EMPTY;
                    pndng_r  <= 1'b0;
                end
            endcase
        end
    end

    // Per-requester saturating grant counters; clr wins over a same-cycle grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (clr) begin
                    cnt_r[i] <= '0;
                end else if (pop_s[i] && (cnt_r[i] != {CNT_W{1'b1}})) begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    // Watchdog: run length of held-but-unconsumed cycles, pinned at the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= '0;
            stall_r     <= 1'b0;
        end else begin
            if (pndng_r && !bus.popin) begin
                if (stall_cnt_r == SC_W'(STALL_LIM)) begin
                    stall_cnt_r <= stall_cnt_r;
                end else begin
                    stall_cnt_r <= stall_cnt_r + SC_W'(1);
                end
            end else begin
                stall_cnt_r <= '0;
            end
            if (clr) begin
                stall_r <= 1'b0;
            end else if (stall_cnt_r == SC_W'(STALL_LIM)) begin
                stall_r <= 1'b1;
            end else begin
                stall_r <= stall_r;
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
        assign gnt_cnt[g*CNT_W +: CNT_W] = cnt_r[g];
    end

    assign bus.req_pop = pop_s;
    assign bus.pndng_o = pndng_r;
    assign bus.data_o  = data_r;
    assign stall       = stall_r;
endmodule

// File: tb/tb_term_src_arbiter.sv
// Directed and randomized bench for term_src_arbiter against a cycle-level reference model.
module tb_term_src_arbiter;
    localparam int N   = 4;
    localparam int W   = 40;
    localparam int CW  = 4;
    localparam int LIM = 255;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            clr = 1'b0;
    logic [N*CW-1:0] gnt_cnt;
    logic            stall;

    term_src_arbiter_if #(.N_REQ(N), .pckg_sz(W)) bus ();

    term_src_arbiter #(.N_REQ(N), .pckg_sz(W), .CNT_W(CW), .STALL_LIM(LIM)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.master),
        .gnt_cnt (gnt_cnt),
        .stall   (stall),
        .clr     (clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [N-1:0] last_pop;

    bit           m_full;
    logic [W-1:0] m_data;
    int           m_ptr;
    int           m_cnt [N];
    int           m_run;
    bit           m_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0; m_data = '0; m_ptr = 0; m_run = 0; m_stall = 1'b0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    task automatic rand_data();
        logic [63:0] t;
        for (int i = 0; i < N; i++) begin
            t = {$urandom(), $urandom()};
            bus.req_data[i*W +: W] = t[W-1:0];
        end
    endtask

    // One clock cycle: predict req_pop from current inputs, then check registered state.
    task automatic step(input string tag);
        int w;
        bit slot, grant, pre_full, pin, pclr;
        logic [N-1:0] cand, exp_pop;
        logic [N*CW-1:0] eg;
        logic [W-1:0] wd;
        #2;
        slot = !m_full || bus.popin;
        cand = bus.req_pndng & bus.req_en;
        w = -1;
        for (int k = 0; k < N; k++) begin
            if (w < 0 && cand[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        end
        grant = slot && (w >= 0);
        exp_pop = grant ? N'(1 << w) : '0;
        chk({tag, ".pop"}, 64'(bus.req_pop), 64'(exp_pop));
        last_pop = bus.req_pop;
        if (bus.req_pop != '0) pops++;
        wd = grant ? bus.req_data[w*W +: W] : '0;
        pre_full = m_full; pin = bus.popin; pclr = clr;
        @(posedge clk);
        #1;
        if (grant) begin
            m_full = 1'b1; m_data = wd; m_ptr = (w + 1) % N;
            if (m_cnt[w] < (1 << CW) - 1) m_cnt[w]++;
        end else if (pin) begin
            m_full = 1'b0;
        end
        if (pclr) for (int i = 0; i < N; i++) m_cnt[i] = 0;
        if (pclr) m_stall = 1'b0;
        else if (m_run >= LIM) m_stall = 1'b1;
        m_run = (pre_full && !pin) ? m_run + 1 : 0;
        for (int i = 0; i < N; i++) eg[i*CW +: CW] = CW'(m_cnt[i]);
        chk({tag, ".pndng"}, 64'(bus.pndng_o), 64'(m_full));
        chk({tag, ".data"},  64'(bus.data_o),  64'(m_data));
        chk({tag, ".cnt"},   64'(gnt_cnt),     64'(eg));
        chk({tag, ".stall"}, 64'(stall),       64'(m_stall));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        bus.req_pndng = 4'hF; bus.req_en = 4'hF; bus.popin = 1'b0;
        rand_data();
        model_reset();
        #12;
        chk("rst.pop",   64'(bus.req_pop), 64'h0);
        chk("rst.pndng", 64'(bus.pndng_o), 64'h0);
        chk("rst.data",  64'(bus.data_o),  64'h0);
        chk("rst.cnt",   64'(gnt_cnt),     64'h0);
        chk("rst.stall", 64'(stall),       64'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single source with a constant head value.
        bus.req_pndng = 4'b0100; bus.req_data[2*W +: W] = 40'hAB_CDEF_0123; bus.popin = 1'b1;
        repeat (6) step("single");
        chk("single.head", 64'(bus.data_o), 64'h00AB_CDEF_0123);
        chk("single.cnt2", 64'(gnt_cnt[2*CW +: CW]), 64'd6);

        // Fairness from reset: two full rounds.
        do_reset();
        bus.req_pndng = 4'hF; bus.popin = 1'b1;
        for (int c = 0; c < 8; c++) begin
            rand_data();
            step("fair");
            chk("fair.order", 64'(last_pop), 64'(4'b0001 << (c % 4)));
        end
        chk("fair.cnt", 64'(gnt_cnt), 64'h2222);

        // Backpressure and watchdog.
        do_reset();
        bus.popin = 1'b0; pops = 0;
        repeat (100) begin rand_data(); step("bp"); end
        chk("bp.early_stall", 64'(stall), 64'h0);
        repeat (200) begin rand_data(); step("bp"); end
        chk("bp.one_pop", 64'(pops), 64'd1);
        chk("bp.stall", 64'(stall), 64'h1);
        bus.popin = 1'b1;
        step("bp.pulse");
        chk("bp.pulse_pop", 64'(last_pop != '0), 64'h1);
        bus.popin = 1'b0;
        step("bp.after");
        chk("bp.sticky", 64'(stall), 64'h1);
        clr = 1'b1; step("bp.clr"); clr = 1'b0;
        chk("bp.cleared", 64'(stall), 64'h0);

        // Enable mask, then a narrower mask mid-run.
        bus.popin = 1'b1; bus.req_en = 4'b1010; bus.req_pndng = 4'hF;
        repeat (6) begin rand_data(); step("en"); end
        bus.req_en = 4'b0010;
        repeat (4) begin
            rand_data(); step("en1");
            chk("en1.only1", 64'(last_pop), 64'(4'b0010));
        end

        // Saturation and clear during a grant.
        clr = 1'b1; step("sat.clr0"); clr = 1'b0;
        bus.req_en = 4'b0001; bus.req_pndng = 4'b0001;
        repeat (20) begin rand_data(); step("sat"); end
        chk("sat.full", 64'(gnt_cnt[0 +: CW]), 64'hF);
        clr = 1'b1; step("sat.clr"); clr = 1'b0;
        chk("sat.zero", 64'(gnt_cnt[0 +: CW]), 64'h0);

        // Asynchronous reset while FULL, pointer returns to requester 0.
        bus.req_en = 4'b0100; bus.req_pndng = 4'hF; bus.popin = 1'b1;
        step("rm.grant2");
        bus.popin = 1'b0;
        step("rm.hold");
        bus.req_en = 4'hF;
        #3;
        reset = 1'b0;
        #1;
        chk("rm.async_pndng", 64'(bus.pndng_o), 64'h0);
        chk("rm.pop_in_reset", 64'(bus.req_pop), 64'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.popin = 1'b1;
        step("rm.first");
        chk("rm.first_winner", 64'(last_pop), 64'(4'b0001));

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            rand_data();
            bus.req_pndng = N'($urandom());
            bus.req_en    = ($urandom_range(0, 3) == 0) ? N'($urandom()) : 4'hF;
            bus.popin     = 1'($urandom());
            clr           = ($urandom_range(0, 15) == 0);
            step("rnd");
        end
        clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
